uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding three byte requesters into one UART byte transmitter.
// Optional feature: define UART_ARB_TIMEOUT_EN to abort a stuck SEND after TIMEOUT_CYCLES.
module uart_tx_arbiter #(
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [2:0]  req,
  input  logic [23:0] req_data,
  output logic [2:0]  ack,
  output logic [2:0]  done,
  output logic [7:0]  tx_data,
  output logic        send_go,
  input  logic        tx_done,
  output logic        busy,
  output logic [1:0]  owner,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_ack;
  logic [2:0]  w_ack_nxt;
  logic [2:0]  r_done;
  logic [2:0]  w_done_nxt;
  logic [7:0]  r_tx_data;
  logic [7:0]  w_tx_data_nxt;
  logic        r_send_go;
  logic        w_send_go_nxt;
  logic [1:0]  r_owner;
  logic [1:0]  w_owner_nxt;
  logic [1:0]  r_last_owner;
  logic [1:0]  w_last_owner_nxt;
  logic        r_busy;
  logic [1:0]  w_grant_idx;
  logic        w_to_expire;

  // First requesting index after 'last', wrapping 2->0; only meaningful when r != 0.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] pick;
    case (last)
      2'd0:    pick = r[1] ? 2'd1 : (r[2] ? 2'd2 : 2'd0);
      2'd1:    pick = r[2] ? 2'd2 : (r[0] ? 2'd0 : 2'd1);
      default: pick = r[0] ? 2'd0 : (r[1] ? 2'd1 : 2'd2);
    endcase
    return pick;
  endfunction

  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    logic [2:0] oh;
    case (idx)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      default: oh = 3'b100;
    endcase
    return oh;
  endfunction

  function automatic logic [7:0] byte_sel(input logic [23:0] d, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      default: b = d[23:16];
    endcase
    return b;
  endfunction

  assign w_grant_idx = rr_pick(req, r_last_owner);

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt      = r_state;
    w_ack_nxt        = 3'b000;
    w_done_nxt       = 3'b000;
    w_tx_data_nxt    = r_tx_data;
    w_send_go_nxt    = r_send_go;
    w_owner_nxt      = r_owner;
    w_last_owner_nxt = r_last_owner;
    case (r_state)
      IDLE: begin
        if (req != 3'b000) begin
          w_state_nxt   = SEND;
          w_ack_nxt     = onehot3(w_grant_idx);
          w_tx_data_nxt = byte_sel(req_data, w_grant_idx);
          w_owner_nxt   = w_grant_idx;
          w_send_go_nxt = 1'b1;
        end else begin
          w_send_go_nxt = 1'b0;
        end
      end
      SEND: begin
        if (tx_done) begin
          w_state_nxt      = GAP;
          w_send_go_nxt    = 1'b0;
          w_done_nxt       = onehot3(r_owner);
          w_last_owner_nxt = r_owner;
        end else if (w_to_expire) begin
          // Abort: owner still loses its turn, but no completion is reported.
          w_state_nxt      = GAP;
          w_send_go_nxt    = 1'b0;
          w_last_owner_nxt = r_owner;
        end else begin
          w_send_go_nxt = 1'b1;
        end
      end
      GAP: begin
        w_state_nxt   = IDLE;
        w_send_go_nxt = 1'b0;
      end
      default: begin
        w_state_nxt   = IDLE;
        w_send_go_nxt = 1'b0;
      end
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state      <= IDLE;
      r_ack        <= 3'b000;
      r_done       <= 3'b000;
      r_tx_data    <= 8'h00;
      r_send_go    <= 1'b0;
      r_owner      <= 2'd0;
      r_last_owner <= 2'd2;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ack        <= w_ack_nxt;
      r_done       <= w_done_nxt;
      r_tx_data    <= w_tx_data_nxt;
      r_send_go    <= w_send_go_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_busy       <= (w_state_nxt != IDLE);
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;
  logic          r_timeout_err;

  // Counts completed SEND cycles; the last allowed cycle is TIMEOUT_CYCLES-1.
  assign w_to_expire = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  // SEND-cycle counter and sticky timeout flag.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_cnt         <= {CW{1'b0}};
      r_timeout_err <= 1'b0;
    end else begin
      if ((r_state == SEND) && (w_state_nxt == SEND)) begin
        r_cnt <= r_cnt + CW'(1);
      end else begin
        r_cnt <= {CW{1'b0}};
      end
      if ((r_state == SEND) && !tx_done && w_to_expire) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign timeout_err = r_timeout_err;
`else
  logic w_unused_timeout;

  assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
  assign w_to_expire      = 1'b0;
  assign timeout_err      = 1'b0;
`endif

  assign ack     = r_ack;
  assign done    = r_done;
  assign tx_data = r_tx_data;
  assign send_go = r_send_go;
  assign busy    = r_busy;
  assign owner   = r_owner;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: driver predicts grants from a round-robin model,
// an independent negedge monitor pops expectations whenever ack or done is presented.
module tb_uart_tx_arbiter;
  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        n_reset;
  logic [2:0]  req;
  logic [23:0] req_data;
  logic [2:0]  ack;
  logic [2:0]  done;
  logic [7:0]  tx_data;
  logic        send_go;
  logic        tx_done;
  logic        busy;
  logic [1:0]  owner;
  logic        timeout_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .n_reset(n_reset), .req(req), .req_data(req_data),
    .ack(ack), .done(done), .tx_data(tx_data), .send_go(send_go),
    .tx_done(tx_done), .busy(busy), .owner(owner), .timeout_err(timeout_err)
  );

  typedef struct {
    int         idx;
    logic [7:0] data;
  } ack_t;

  ack_t       ack_q[$];
  int         done_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] bytes[3];
  logic [2:0] cur_mask;
  int         model_last;
  int         pend_idx;
  bit         found;
  logic [2:0] nm;
  int         cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arbitration rule: first requester found counting up from last+1, modulo 3.
  function automatic int rr(input logic [2:0] m, input int last);
    int i;
    for (int k = 1; k <= 3; k++) begin
      i = (last + k) % 3;
      if (m[i]) return i;
    end
    return 0;
  endfunction

  // Monitor: every ack/done the DUT presents must match the head of its queue.
  always @(negedge clk) begin
    if (n_reset === 1'b1) begin
      if (ack !== 3'b000) begin
        if (ack_q.size() == 0) begin
          chk("unexpected_ack", 32'(ack), 32'd0);
        end else begin
          ack_t e;
          e = ack_q.pop_front();
          chk("ack_onehot", 32'(ack), 32'd1 << e.idx);
          chk("ack_tx_data", 32'(tx_data), 32'(e.data));
          chk("ack_owner", 32'(owner), 32'(e.idx));
          chk("ack_send_go", 32'(send_go), 32'd1);
        end
      end
      if (done !== 3'b000) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          int d;
          d = done_q.pop_front();
          chk("done_onehot", 32'(done), 32'd1 << d);
        end
      end
    end
  end

  task automatic apply_mask(input logic [2:0] m, input bit rnd, input int last);
    ack_t e;
    for (int i = 0; i < 3; i++) begin
      if (rnd && (!m[i] || !cur_mask[i])) bytes[i] = 8'($urandom_range(0, 255));
    end
    cur_mask = m;
    req      = m;
    req_data = {bytes[2], bytes[1], bytes[0]};
    if (m != 3'b000) begin
      pend_idx = rr(m, last);
      e.idx    = pend_idx;
      e.data   = bytes[pend_idx];
      ack_q.push_back(e);
    end
  endtask

  task automatic wait_ack(output bit f);
    int n;
    n = 0;
    @(negedge clk);
    chk("grant_latency", 32'(ack != 3'b000), 32'd1);
    while (ack == 3'b000 && n < 10) begin
      @(negedge clk);
      n++;
    end
    f = (ack != 3'b000);
    if (!f) chk("ack_wait_bound", 32'(f), 32'd1);
  endtask

  // One full transfer: grant, hold for d cycles, tx_done, GAP, back to IDLE.
  task automatic run_transfer(input int d, input logic [2:0] next_m, input bit rnd);
    bit         f;
    int         g;
    logic [7:0] cd;
    wait_ack(f);
    if (!f) return;
    g  = pend_idx;
    cd = bytes[g];
    apply_mask(next_m, rnd, g);
    repeat (d) begin
      @(negedge clk);
      chk("send_go_hold", 32'(send_go), 32'd1);
      chk("tx_data_hold", 32'(tx_data), 32'(cd));
    end
    tx_done = 1'b1;
    done_q.push_back(g);
    @(negedge clk);
    tx_done    = 1'b0;
    model_last = g;
    chk("send_go_clear", 32'(send_go), 32'd0);
    chk("busy_in_gap", 32'(busy), 32'd1);
    @(negedge clk);
    chk("busy_after_gap", 32'(busy), 32'd0);
    chk("send_go_in_gap", 32'(send_go), 32'd0);
  endtask

  task automatic idle_check(input int n, input bit stray);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_send_go", 32'(send_go), 32'd0);
      tx_done = (stray && i == 0 && n > 1);
    end
    tx_done = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_reset    = 1'b0;
    req        = 3'b000;
    req_data   = 24'h000000;
    tx_done    = 1'b0;
    cur_mask   = 3'b000;
    model_last = 2;
    pend_idx   = 0;
    bytes      = '{8'h00, 8'h00, 8'h00};
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_send_go", 32'(send_go), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    n_reset = 1'b1;

    // Single request from requester 1.
    bytes[1] = 8'hA5;
    apply_mask(3'b010, 1'b0, model_last);
    run_transfer(9, 3'b000, 1'b0);
    // Stray tx_done while idle.
    idle_check(4, 1'b1);

    // Reset three cycles into SEND.
    bytes[0] = 8'h5A;
    apply_mask(3'b001, 1'b0, model_last);
    wait_ack(found);
    repeat (3) @(negedge clk);
    chk("send_go_pre_reset", 32'(send_go), 32'd1);
    #2 n_reset = 1'b0;
    #1;
    chk("send_go_async_reset", 32'(send_go), 32'd0);
    chk("busy_async_reset", 32'(busy), 32'd0);
    req        = 3'b000;
    cur_mask   = 3'b000;
    model_last = 2;
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    chk("owner_after_reset", 32'(owner), 32'd0);
    idle_check(4, 1'b1);

    // All three requesting, then fairness between 0 and 2.
    bytes[0] = 8'h11;
    bytes[1] = 8'h22;
    bytes[2] = 8'h33;
    apply_mask(3'b111, 1'b0, model_last);
    run_transfer(3, 3'b111, 1'b0);
    run_transfer(3, 3'b111, 1'b0);
    run_transfer(3, 3'b111, 1'b0);
    run_transfer(3, 3'b101, 1'b0);
    run_transfer(2, 3'b101, 1'b0);
    run_transfer(2, 3'b000, 1'b0);
    idle_check(2, 1'b0);

    // Randomized traffic, request mask reshuffled during each SEND.
    apply_mask(3'($urandom_range(1, 7)), 1'b1, model_last);
    for (int r = 0; r < 40; r++) begin
      nm = 3'($urandom_range(0, 7));
      run_transfer($urandom_range(1, 12), nm, 1'b1);
      if (nm == 3'b000) begin
        idle_check($urandom_range(1, 3), 1'($urandom_range(0, 1)));
        apply_mask(3'($urandom_range(1, 7)), 1'b1, model_last);
      end
    end
    run_transfer(2, 3'b000, 1'b1);
    idle_check(2, 1'b0);

`ifdef UART_ARB_TIMEOUT_EN
    bytes[0] = 8'hC3;
    apply_mask(3'b001, 1'b0, model_last);
    wait_ack(found);
    apply_mask(3'b000, 1'b0, model_last);
    cnt = 1;
    while (send_go && cnt < 200) begin
      @(negedge clk);
      if (send_go) cnt++;
    end
    model_last = 0;
    chk("timeout_send_cycles", 32'(cnt), 32'(TO));
    chk("timeout_err_set", 32'(timeout_err), 32'd1);
    chk("timeout_busy_gap", 32'(busy), 32'd1);
    @(negedge clk);
    chk("timeout_busy_idle", 32'(busy), 32'd0);
    bytes[0] = 8'h3C;
    apply_mask(3'b001, 1'b0, model_last);
    run_transfer(4, 3'b000, 1'b0);
    chk("timeout_err_sticky", 32'(timeout_err), 32'd1);
`else
    chk("timeout_err_off", 32'(timeout_err), 32'd0);
`endif

    repeat (3) @(negedge clk);
    chk("ack_q_drained", 32'(ack_q.size()), 32'd0);
    chk("done_q_drained", 32'(done_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
